lib_skid_pipe: RTL and testbench
================================

# lib_skid_pipe

Multi-stage valid/ready register pipeline built from two-entry skid stages, with the ready path fully registered. It carries a data stream across long or congested datapath segments under downstream backpressure, with no combinational path from `out_rdy` to `in_rdy`. It complements the free-running, unstalled pipelines in the datapath libraries and sits between producer and consumer blocks that need flow control.

## Interface
- `WIDTH`, 8: data width in bits.
- `DEPTH`, 2: number of skid stages, minimum 1. Total capacity is 2*DEPTH beats.
- `CNT_W`, $clog2(2*DEPTH+1): width of the occupancy counter.

- `clk` input 1: the single clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `in_vld` input 1: upstream beat valid.
- `in_data` input WIDTH: upstream beat data.
- `in_rdy` output 1: pipe can accept a beat. Driven directly from flops.
- `out_vld` output 1: downstream beat valid. Driven directly from flops.
- `out_data` output WIDTH: downstream beat data. Driven directly from flops.
- `out_rdy` input 1: downstream accepts the beat.
- `flush` input 1: synchronous discard of all held beats.
- `count` output CNT_W: number of beats held, 0 to 2*DEPTH.

## Operation
- Transfer rule: a transfer occurs on a rising edge where vld=1 and rdy=1. Beats leave strictly in acceptance order, with no loss and no duplication.
- Each stage k has a main register (M) and a skid register (S), plus a state:
  - EMPTY: M and S invalid.
  - BUSY: M valid, S invalid.
  - FULL: M and S valid.
- Stage k drives vld = (state != EMPTY) and data = M toward stage k+1.
- Stage k drives rdy = (state != FULL) toward stage k-1. This value is a flop decode.
- Stage state transitions (push = transfer into the stage, pop = transfer out of the stage):
  - EMPTY + push → BUSY; M ← in.
  - BUSY + push, no pop → FULL; S ← in.
  - BUSY + pop, no push → EMPTY.
  - BUSY + push + pop → BUSY; M ← in.
  - FULL + pop → BUSY; M ← S.
  - FULL + push cannot occur, because rdy=0.
- Stage 0 faces `in_*`; stage DEPTH-1 faces `out_*`.
- `count` is incremented on an input transfer and decremented on an output transfer. It is unchanged when both happen in the same cycle.
- `flush`=1 at an edge:
  - Every stage goes to EMPTY and `count` goes to 0.
  - An input beat presented in that cycle is discarded, even if `in_rdy`=1.
  - An output transfer in that cycle counts as delivered.
- Data registers carry no reset and are not cleared by flush. Only state flops are reset.
- `in_vld` may change at any time; a beat is only defined by a transfer.

## Timing
- Reset values: `out_vld`=0, `in_rdy`=1, `count`=0. `out_data` is undefined until the first `out_vld`=1.
- Latency: a beat accepted into an empty pipe at edge N gives `out_vld`=1 after edge N+DEPTH-1. With DEPTH=2, a beat accepted at edge 0 shows `out_vld`=1 in the cycle after edge 1.
- Throughput: with `out_rdy` held at 1, one beat per cycle is sustained indefinitely and `in_rdy` stays at 1.
- Backpressure:
  - If `out_rdy`=0 from empty while input streams continuously, exactly 2*DEPTH beats are accepted.
  - `in_rdy` falls the cycle after the 2*DEPTH-th acceptance.
- Release: the edge after `out_rdy` returns to 1, the head stage drops out of FULL. `in_rdy` rises within DEPTH cycles.
- Reset asserted mid-stream: all outputs take their reset values immediately, asynchronously. Held beats are lost.
- Deassertion of `rstn` must be synchronous to `clk` (done externally).

## Test plan
1. **Reset and single beat.** DEPTH=2. Release reset, then send one beat 0xA5.
   - Required: `in_rdy`=1 and `out_vld`=0 after reset.
   - Required: 0xA5 appears with `out_vld`=1 two cycles after acceptance, and `count` goes 1 → 0 on the output transfer.
2. **Full-rate stream.** Send 64 beats 0x00..0x3F back-to-back with `out_rdy`=1.
   - Required: all beats arrive in order with no gaps after the first.
   - Required: `in_rdy` never drops and `count` stays at or below DEPTH.
3. **Fill under backpressure.** Hold `out_rdy`=0 and stream 0x10, 0x11, …
   - Required: exactly 4 beats (0x10–0x13) are accepted and `count`=4.
   - Required: `in_rdy`=0 the following cycle.
   - Then raise `out_rdy`. Required: 0x10, 0x11, 0x12, 0x13 are delivered in order, then 0x14.
4. **Random handshakes.** Randomize `in_vld` and `out_rdy` at 50% each over 10k cycles.
   - Required: the scoreboard sees an in-order, lossless stream.
   - Required: `count` always equals accepted minus delivered.
   - Required: `in_rdy` and `out_vld` never glitch within a cycle (flop-driven).
5. **Flush.** Fill to 3 beats, then pulse `flush` with `in_vld`=1, data 0xEE.
   - Required: next cycle `count`=0, `out_vld`=0, `in_rdy`=1.
   - Required: 0xEE is never delivered.
6. **Async reset mid-stream.** Assert `rstn`=0 mid-cycle while the pipe is full.
   - Required: `out_vld`=0, `in_rdy`=1, `count`=0 immediately, before the next clock edge.
   - Required: after release, streaming behaves as in scenario 2.

Source files
------------

// File: rtl/lib_skid_pipe_if.sv
// Valid/ready stream bundle for lib_skid_pipe: upstream beat, downstream beat,
// flush request and occupancy. master = producer/consumer side, slave = the pipe.
interface lib_skid_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
);
    logic             in_vld;
    logic [WIDTH-1:0] in_data;
    logic             in_rdy;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic             out_rdy;
    logic             flush;
    logic [CNT_W-1:0] count;

    modport master (
        output in_vld, in_data, out_rdy, flush,
        input  in_rdy, out_vld, out_data, count
    );

    modport slave (
        input  in_vld, in_data, out_rdy, flush,
        output in_rdy, out_vld, out_data, count
    );
endinterface

// File: rtl/lib_skid_pipe.sv
// Chain of two-entry skid stages; every stage's vld/rdy is a single state flop bit,
// so there is no combinational path from out_rdy back to in_rdy.
module lib_skid_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(2*DEPTH+1)
) (
    input  logic             clk,
    input  logic             rstn,
    lib_skid_pipe_if.slave   bus
);
    // bit0 = M valid (drives vld), bit1 = S valid (inverted, drives rdy)
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [DEPTH-1:0] stg_vld;
    logic [DEPTH-1:0] stg_rdy;
    logic [DEPTH-1:0] up_vld;
    logic [DEPTH-1:0] dn_rdy;
    logic [DEPTH-1:0] push;
    logic [DEPTH-1:0] pop;
    logic [WIDTH-1:0] up_data [DEPTH];
    logic [WIDTH-1:0] m_data  [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [1:0]       state_reg;
            logic [1:0]       state_next;
            logic [WIDTH-1:0] m_reg;
            logic [WIDTH-1:0] s_reg;

            if (gi == 0) begin : g_head
                assign up_vld[gi]  = bus.in_vld;
                assign up_data[gi] = bus.in_data;
            end else begin : g_link
                assign up_vld[gi]  = stg_vld[gi-1];
                assign up_data[gi] = m_data[gi-1];
            end

            if (gi == DEPTH-1) begin : g_tail
                assign dn_rdy[gi] = bus.out_rdy;
            end else begin : g_mid
                assign dn_rdy[gi] = stg_rdy[gi+1];
            end

            assign stg_vld[gi] = state_reg[0];
            assign stg_rdy[gi] = ~state_reg[1];
            assign push[gi]    = up_vld[gi] & stg_rdy[gi];
            assign pop[gi]     = stg_vld[gi] & dn_rdy[gi];
            assign m_data[gi]  = m_reg;

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    ST_EMPTY: if (push[gi]) state_next = ST_BUSY;
                    ST_BUSY: begin
                        if (push[gi] && !pop[gi])      state_next = ST_FULL;
                        else if (!push[gi] && pop[gi]) state_next = ST_EMPTY;
                    end
                    ST_FULL:  if (pop[gi]) state_next = ST_BUSY;
                    default:  state_next = ST_EMPTY;
                endcase
                if (bus.flush) state_next = ST_EMPTY;
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) state_reg <= ST_EMPTY;
                else       state_reg <= state_next;
            end

            // Payload flops are unreset; only the state decides what is valid.
            always_ff @(posedge clk) begin
                if (state_reg == ST_FULL && pop[gi])
                    m_reg <= s_reg;
                else if (push[gi] && (state_reg == ST_EMPTY || pop[gi]))
                    m_reg <= up_data[gi];
                else if (push[gi])
                    s_reg <= up_data[gi];
            end
        end
    endgenerate

    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign in_xfer  = bus.in_vld & stg_rdy[0];
    assign out_xfer = stg_vld[DEPTH-1] & bus.out_rdy;

    always_comb begin
        count_next = count_reg;
        if (bus.flush)
            count_next = '0;
        else if (in_xfer && !out_xfer)
            count_next = count_reg + CNT_W'(1);
        else if (!in_xfer && out_xfer)
            count_next = count_reg - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) count_reg <= '0;
        else       count_reg <= count_next;
    end

    assign bus.in_rdy   = stg_rdy[0];
    assign bus.out_vld  = stg_vld[DEPTH-1];
    assign bus.out_data = m_data[DEPTH-1];
    assign bus.count    = count_reg;
endmodule

// File: tb/tb_lib_skid_pipe.sv
// Randomised and directed checks of lib_skid_pipe against a queue model of an
// in-order, lossless stream whose occupancy is accepted minus delivered.
module tb_lib_skid_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CAP   = 2*DEPTH;
    localparam int CNT_W = $clog2(2*DEPTH+1);

    logic clk;
    logic rstn;

    lib_skid_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    lib_skid_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] dq[$];
    bit glitch_chk = 1'b0;
    bit log_beats = 1'b1;

    // One clock cycle: settle, observe transfers at the negedge, then the edge.
    task automatic tick();
        logic r0, v0;
        r0 = bus.in_rdy;
        v0 = bus.out_vld;
        @(negedge clk);
        if (glitch_chk) begin
            n_cmp++;
            if (bus.in_rdy !== r0 || bus.out_vld !== v0) begin
                n_err++;
                $display("FAIL glitch: in_rdy %b->%b out_vld %b->%b within one cycle", r0, bus.in_rdy, v0, bus.out_vld);
            end
        end
        if (bus.out_vld === 1'b1 && bus.out_rdy) begin
            dq.push_back(bus.out_data);
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard: got beat %h, required none (model empty)", bus.out_data);
            end else begin
                if (bus.out_data !== q[0]) begin
                    n_err++;
                    $display("FAIL scoreboard: got %h, required %h", bus.out_data, q[0]);
                end
                void'(q.pop_front());
            end
            if (log_beats) $display("%0t out beat %h", $time, bus.out_data);
        end
        if (bus.in_vld && bus.in_rdy === 1'b1 && !bus.flush) q.push_back(bus.in_data);
        if (bus.flush) q.delete();
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.count !== CNT_W'(q.size())) begin
            n_err++;
            $display("FAIL count: got %0d, required %0d", bus.count, q.size());
        end
    endtask

    task automatic drain();
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 40 && (q.size() != 0 || bus.out_vld !== 1'b0); i++) tick();
        n_cmp++;
        if (q.size() != 0 || bus.out_vld !== 1'b0) begin
            n_err++;
            $display("FAIL drain: out_vld %b with %0d beats left, required empty", bus.out_vld, q.size());
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.in_vld = 1'b0; bus.in_data = '0; bus.out_rdy = 1'b0; bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        n_cmp++;
        if (bus.in_rdy !== 1'b1 || bus.out_vld !== 1'b0 || bus.count !== '0) begin
            n_err++;
            $display("FAIL reset: in_rdy %b out_vld %b count %0d, required 1 0 0", bus.in_rdy, bus.out_vld, bus.count);
        end
    endtask

    task automatic test_single_beat();
        bus.out_rdy = 1'b1;
        bus.in_vld  = 1'b1;
        bus.in_data = 8'hA5;
        dq.delete();
        tick();
        bus.in_vld = 1'b0;
        n_cmp++;
        if (bus.count !== CNT_W'(1) || bus.out_vld !== 1'b0) begin
            n_err++;
            $display("FAIL single_accept: count %0d out_vld %b, required 1 0", bus.count, bus.out_vld);
        end
        tick();
        n_cmp++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== 8'hA5) begin
            n_err++;
            $display("FAIL single_latency: out_vld %b data %h, required 1 a5", bus.out_vld, bus.out_data);
        end
        tick();
        n_cmp++;
        if (bus.count !== '0 || dq.size() != 1) begin
            n_err++;
            $display("FAIL single_out: count %0d delivered %0d, required 0 1", bus.count, dq.size());
        end
    endtask

    task automatic test_full_rate(input int n, input logic [WIDTH-1:0] base);
        int sent;
        sent = 0;
        dq.delete();
        bus.out_rdy = 1'b1;
        for (int c = 0; c < n + 10 && dq.size() < n; c++) begin
            bus.in_vld  = (sent < n);
            bus.in_data = base + WIDTH'(sent);
            if (sent < n) begin
                n_cmp++;
                if (bus.in_rdy !== 1'b1) begin
                    n_err++;
                    $display("FAIL stream_in_rdy: got %b at beat %0d, required 1", bus.in_rdy, sent);
                end
                sent++;
            end
            tick();
            n_cmp++;
            if (bus.count > CNT_W'(DEPTH)) begin
                n_err++;
                $display("FAIL stream_count: got %0d, required <= %0d", bus.count, DEPTH);
            end
            if (dq.size() > 0 && dq.size() < n) begin
                n_cmp++;
                if (bus.out_vld !== 1'b1) begin
                    n_err++;
                    $display("FAIL stream_gap: out_vld %b after %0d beats, required 1", bus.out_vld, dq.size());
                end
            end
        end
        bus.in_vld = 1'b0;
        n_cmp++;
        if (dq.size() != n) begin
            n_err++;
            $display("FAIL stream_total: delivered %0d, required %0d", dq.size(), n);
        end
        for (int i = 0; i < n && i < dq.size(); i++) begin
            n_cmp++;
            if (dq[i] !== base + WIDTH'(i)) begin
                n_err++;
                $display("FAIL stream_order: beat %0d got %h, required %h", i, dq[i], base + WIDTH'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        logic took;
        drain();
        dq.delete();
        acc = 0;
        bus.out_rdy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.in_vld  = 1'b1;
            bus.in_data = 8'h10 + WIDTH'(acc);
            took = bus.in_rdy;
            tick();
            if (took) begin
                acc++;
                if (acc == CAP) begin
                    n_cmp++;
                    if (bus.in_rdy !== 1'b0) begin
                        n_err++;
                        $display("FAIL bp_in_rdy: got %b after last acceptance, required 0", bus.in_rdy);
                    end
                end
            end
        end
        n_cmp++;
        if (acc != CAP || bus.count !== CNT_W'(CAP)) begin
            n_err++;
            $display("FAIL bp_fill: accepted %0d count %0d, required %0d %0d", acc, bus.count, CAP, CAP);
        end
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 20 && dq.size() < 5; c++) begin
            bus.in_data = 8'h10 + WIDTH'(acc);
            took = bus.in_rdy;
            tick();
            if (took) acc++;
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= dq.size() || dq[i] !== 8'h10 + WIDTH'(i)) begin
                n_err++;
                $display("FAIL bp_release: beat %0d got %h, required %h", i, (i < dq.size()) ? dq[i] : 8'hxx, 8'h10 + WIDTH'(i));
            end
        end
        drain();
    endtask

    task automatic test_random();
        dq.delete();
        glitch_chk = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            bus.in_vld  = 1'($urandom_range(0, 1));
            bus.in_data = WIDTH'($urandom);
            bus.out_rdy = 1'($urandom_range(0, 1));
            tick();
        end
        glitch_chk = 1'b0;
        drain();
    endtask

    task automatic test_flush();
        int acc;
        acc = 0;
        bus.out_rdy = 1'b0;
        for (int c = 0; c < 10 && acc < 3; c++) begin
            bus.in_vld  = 1'b1;
            bus.in_data = WIDTH'($urandom_range(0, 8'hED));
            if (bus.in_rdy === 1'b1) acc++;
            tick();
        end
        bus.in_vld  = 1'b1;
        bus.in_data = 8'hEE;
        bus.flush   = 1'b1;
        tick();
        bus.flush  = 1'b0;
        bus.in_vld = 1'b0;
        n_cmp++;
        if (bus.count !== '0 || bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL flush: count %0d out_vld %b in_rdy %b, required 0 0 1", bus.count, bus.out_vld, bus.in_rdy);
        end
        dq.delete();
        bus.out_rdy = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (dq.size() != 0) begin
            n_err++;
            $display("FAIL flush_discard: delivered %0d beats (first %h), required 0", dq.size(), dq[0]);
        end
    endtask

    task automatic test_async_reset();
        bus.out_rdy = 1'b0;
        for (int c = 0; c < 20 && bus.in_rdy === 1'b1; c++) begin
            bus.in_vld  = 1'b1;
            bus.in_data = WIDTH'($urandom);
            tick();
        end
        bus.in_vld = 1'b0;
        n_cmp++;
        if (bus.count !== CNT_W'(CAP)) begin
            n_err++;
            $display("FAIL arst_fill: count %0d, required %0d", bus.count, CAP);
        end
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1 || bus.count !== '0) begin
            n_err++;
            $display("FAIL arst: out_vld %b in_rdy %b count %0d before edge, required 0 1 0", bus.out_vld, bus.in_rdy, bus.count);
        end
        q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        test_full_rate(32, 8'h80);
        drain();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_full_rate(64, 8'h00);
        drain();
        test_backpressure();
        log_beats = 1'b0;
        test_random();
        log_beats = 1'b1;
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
